// File: rtl/pkt_merge_arb.sv
// pkt_merge_arb: two-input packet merge with packet-granular round-robin arbitration.
// Pops first-word-fall-through FIFOs fi0/fi1 and holds the grant until the EOP word
// has been popped, so packets never interleave. A single registered output stage
// drives a valid/ready port.
// Optional feature macro: PKT_MERGE_STATS_EN adds per-input packet counters
// (pkt_cnt0/pkt_cnt1, width CW).
module pkt_merge_arb #(
    parameter int DW      = 153,
    parameter int EOP_BIT = 152
`ifdef PKT_MERGE_STATS_EN
    ,
    parameter int CW      = 16
`endif
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] fi0_d_out,
    input  logic          fi0_empty,
    output logic          fi0_deq,
    input  logic [DW-1:0] fi1_d_out,
    input  logic          fi1_empty,
    output logic          fi1_deq,
    output logic [DW-1:0] oport_data,
    output logic          oport_valid,
    input  logic          oport_ready
`ifdef PKT_MERGE_STATS_EN
    ,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    logic          space;
    logic          deq0;
    logic          deq1;
    logic          load;
    logic          eop0;
    logic          eop1;
    logic [DW-1:0] sel_word;

    // Pop decision: only the granted FIFO, only when it has a word and the output slot frees up
    always_comb begin
        space    = !valid_q || oport_ready;
        deq0     = (state_q == PKT0) && !fi0_empty && space;
        deq1     = (state_q == PKT1) && !fi1_empty && space;
        load     = deq0 || deq1;
        eop0     = deq0 && fi0_d_out[EOP_BIT];
        eop1     = deq1 && fi1_d_out[EOP_BIT];
        sel_word = deq1 ? fi1_d_out : fi0_d_out;
    end

    assign fi0_deq = deq0;
    assign fi1_deq = deq1;

    // Grant FSM: arbitrate in IDLE only, release the grant after the EOP pop
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // last_q names the input served most recently; prefer the other one
                if (!fi0_empty && !fi1_empty) begin
                    state_d = last_q ? PKT0 : PKT1;
                end else if (!fi0_empty) begin
                    state_d = PKT0;
                end else if (!fi1_empty) begin
                    state_d = PKT1;
                end
            end
            PKT0: begin
                if (eop0) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            PKT1: begin
                if (eop1) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on pop, drop valid once the consumer has taken the word
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = sel_word;
            valid_d = 1'b1;
        end else if (valid_q && oport_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; last resets to 1 so fi0 wins the first tie
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign oport_data  = data_q;
    assign oport_valid = valid_q;

`ifdef PKT_MERGE_STATS_EN
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    // Packet counters bump on each EOP pop and wrap naturally at full scale
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (eop0) begin
            cnt0_d = cnt0_q + CW'(1);
        end
        if (eop1) begin
            cnt1_d = cnt1_q + CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_pkt_merge_arb.sv
// Directed testbench for pkt_merge_arb: FIFO models on both inputs, an output
// log of every accepted word, and hand-computed expected sequences.
module tb_pkt_merge_arb;

    localparam int DW = 153;

    logic          CLK;
    logic          RST_N;
    logic [DW-1:0] fi0_d_out;
    logic          fi0_empty;
    logic          fi0_deq;
    logic [DW-1:0] fi1_d_out;
    logic          fi1_empty;
    logic          fi1_deq;
    logic [DW-1:0] oport_data;
    logic          oport_valid;
    logic          oport_ready;
`ifdef PKT_MERGE_STATS_EN
    logic [3:0]    pkt_cnt0;
    logic [3:0]    pkt_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    // FIFO models: written by the stimulus, popped on the DUT's deq
    logic [DW-1:0] mem0 [0:63];
    logic [DW-1:0] mem1 [0:63];
    int unsigned   wr0 = 0;
    int unsigned   wr1 = 0;
    int unsigned   rd0 = 0;
    int unsigned   rd1 = 0;

    assign fi0_empty = (rd0 == wr0);
    assign fi1_empty = (rd1 == wr1);
    assign fi0_d_out = mem0[rd0 % 64];
    assign fi1_d_out = mem1[rd1 % 64];

    always @(posedge CLK) begin
        if (fi0_deq) rd0 <= rd0 + 1;
        if (fi1_deq) rd1 <= rd1 + 1;
    end

    // Output log and protocol violation counter
    logic [DW-1:0] outlog [0:127];
    int unsigned   nlog = 0;
    int unsigned   viol = 0;

    always @(posedge CLK) begin
        if (oport_valid && oport_ready) begin
            outlog[nlog % 128] <= oport_data;
            nlog <= nlog + 1;
        end
        if ((fi0_deq && fi1_deq) || (fi0_deq && fi0_empty) ||
            (fi1_deq && fi1_empty) || (!RST_N && (fi0_deq || fi1_deq))) begin
            viol <= viol + 1;
        end
    end

    pkt_merge_arb #(
        .DW(DW),
        .EOP_BIT(152)
`ifdef PKT_MERGE_STATS_EN
        ,
        .CW(4)
`endif
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .fi0_d_out(fi0_d_out),
        .fi0_empty(fi0_empty),
        .fi0_deq(fi0_deq),
        .fi1_d_out(fi1_d_out),
        .fi1_empty(fi1_empty),
        .fi1_deq(fi1_deq),
        .oport_data(oport_data),
        .oport_valid(oport_valid),
        .oport_ready(oport_ready)
`ifdef PKT_MERGE_STATS_EN
        ,
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] w(input logic eop, input logic [7:0] port,
                                        input logic [7:0] idx);
        return {eop, 136'd0, port, idx};
    endfunction

    task automatic push0(input logic [DW-1:0] v);
        mem0[wr0 % 64] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [DW-1:0] v);
        mem1[wr1 % 64] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic enter_reset();
        cyc();
        RST_N = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        logic [5:0]  deq_v;
        logic [5:0]  vld_v;
        logic [5:0]  deq1_v;
        int unsigned base;

        RST_N       = 1'b1;
        oport_ready = 1'b1;
        #2;
        RST_N = 1'b0;

        // Test 1: 3-word packet from fi0 only
        push0(w(1'b0, 8'h00, 8'd0));
        push0(w(1'b0, 8'h00, 8'd1));
        push0(w(1'b1, 8'h00, 8'd2));
        cyc();
        cyc();
        chk("rst_valid", oport_valid, 0);
        chk("rst_data", oport_data, 0);
        chk("rst_deq0", fi0_deq, 0);
        base  = nlog;
        RST_N = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) cyc();
            deq_v[i]  = fi0_deq;
            vld_v[i]  = oport_valid;
            deq1_v[i] = fi1_deq;
        end
        chk("t1_deq0_pattern", deq_v, 6'b001110);
        chk("t1_valid_pattern", vld_v, 6'b011100);
        chk("t1_deq1_pattern", deq1_v, 6'b000000);
        chk("t1_count", nlog - base, 3);
        chk("t1_w0", outlog[base + 0], w(1'b0, 8'h00, 8'd0));
        chk("t1_w1", outlog[base + 1], w(1'b0, 8'h00, 8'd1));
        chk("t1_w2", outlog[base + 2], w(1'b1, 8'h00, 8'd2));

        // Test 2: two 2-word packets on each input, round-robin order
        enter_reset();
        push0(w(1'b0, 8'h10, 8'd0));
        push0(w(1'b1, 8'h10, 8'd1));
        push0(w(1'b0, 8'h11, 8'd0));
        push0(w(1'b1, 8'h11, 8'd1));
        push1(w(1'b0, 8'h20, 8'd0));
        push1(w(1'b1, 8'h20, 8'd1));
        push1(w(1'b0, 8'h21, 8'd0));
        push1(w(1'b1, 8'h21, 8'd1));
        base  = nlog;
        RST_N = 1'b1;
        repeat (25) cyc();
        chk("t2_count", nlog - base, 8);
        chk("t2_o0", outlog[base + 0], w(1'b0, 8'h10, 8'd0));
        chk("t2_o1", outlog[base + 1], w(1'b1, 8'h10, 8'd1));
        chk("t2_o2", outlog[base + 2], w(1'b0, 8'h20, 8'd0));
        chk("t2_o3", outlog[base + 3], w(1'b1, 8'h20, 8'd1));
        chk("t2_o4", outlog[base + 4], w(1'b0, 8'h11, 8'd0));
        chk("t2_o5", outlog[base + 5], w(1'b1, 8'h11, 8'd1));
        chk("t2_o6", outlog[base + 6], w(1'b0, 8'h21, 8'd0));
        chk("t2_o7", outlog[base + 7], w(1'b1, 8'h21, 8'd1));

        // Test 3: granted fi0 runs dry mid-packet while fi1 waits
        enter_reset();
        push0(w(1'b0, 8'h30, 8'd0));
        push1(w(1'b0, 8'h40, 8'd0));
        push1(w(1'b1, 8'h40, 8'd1));
        base  = nlog;
        RST_N = 1'b1;
        #1;
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_stall_deq1_%0d", i), fi1_deq, 0);
            if (i != 4) cyc();
        end
        push0(w(1'b0, 8'h30, 8'd1));
        push0(w(1'b0, 8'h30, 8'd2));
        push0(w(1'b1, 8'h30, 8'd3));
        repeat (15) cyc();
        chk("t3_count", nlog - base, 6);
        chk("t3_o0", outlog[base + 0], w(1'b0, 8'h30, 8'd0));
        chk("t3_o1", outlog[base + 1], w(1'b0, 8'h30, 8'd1));
        chk("t3_o2", outlog[base + 2], w(1'b0, 8'h30, 8'd2));
        chk("t3_o3", outlog[base + 3], w(1'b1, 8'h30, 8'd3));
        chk("t3_o4", outlog[base + 4], w(1'b0, 8'h40, 8'd0));
        chk("t3_o5", outlog[base + 5], w(1'b1, 8'h40, 8'd1));

        // Test 4: backpressure holds the output word and stops popping
        enter_reset();
        push0(w(1'b0, 8'h50, 8'd0));
        push0(w(1'b0, 8'h50, 8'd1));
        push0(w(1'b0, 8'h50, 8'd2));
        push0(w(1'b1, 8'h50, 8'd3));
        RST_N = 1'b1;
        #1;
        cyc();
        cyc();
        chk("t4_n2_valid", oport_valid, 1);
        chk("t4_n2_data", oport_data, w(1'b0, 8'h50, 8'd0));
        oport_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) cyc();
            chk($sformatf("t4_hold_data_%0d", i), oport_data, w(1'b0, 8'h50, 8'd0));
            chk($sformatf("t4_hold_valid_%0d", i), oport_valid, 1);
            chk($sformatf("t4_hold_deq_%0d", i), {fi0_deq, fi1_deq}, 2'b00);
        end
        oport_ready = 1'b1;
        cyc();
        chk("t4_n5_data", oport_data, w(1'b0, 8'h50, 8'd1));
        cyc();
        chk("t4_n6_data", oport_data, w(1'b0, 8'h50, 8'd2));
        cyc();
        chk("t4_n7_data", oport_data, w(1'b1, 8'h50, 8'd3));
        cyc();
        chk("t4_n8_valid", oport_valid, 0);

        // Test 5: asynchronous reset between clock edges mid-packet
        enter_reset();
        push0(w(1'b0, 8'h60, 8'd0));
        push0(w(1'b0, 8'h60, 8'd1));
        push0(w(1'b0, 8'h60, 8'd2));
        push0(w(1'b1, 8'h60, 8'd3));
        base  = nlog;
        RST_N = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
        chk("t5_pre_valid", oport_valid, 1);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("t5_async_valid", oport_valid, 0);
        chk("t5_async_deq", {fi0_deq, fi1_deq}, 2'b00);
        cyc();
        chk("t5_held_valid", oport_valid, 0);
        chk("t5_held_deq", {fi0_deq, fi1_deq}, 2'b00);
        RST_N = 1'b1;
        #1;
        chk("t5_release_idle_deq", fi0_deq, 0);
        repeat (6) cyc();
        chk("t5_count", nlog - base, 3);
        chk("t5_o0", outlog[base + 0], w(1'b0, 8'h60, 8'd0));
        chk("t5_o1", outlog[base + 1], w(1'b0, 8'h60, 8'd1));
        chk("t5_o2", outlog[base + 2], w(1'b1, 8'h60, 8'd3));

`ifdef PKT_MERGE_STATS_EN
        // Test 6: 17 single-word packets from fi1 wrap the 4-bit counter to 1
        enter_reset();
        chk("t6_rst_cnt1", pkt_cnt1, 0);
        for (int i = 0; i < 17; i++) begin
            push1(w(1'b1, 8'h70, 8'(i)));
        end
        base  = nlog;
        RST_N = 1'b1;
        repeat (45) cyc();
        chk("t6_count", nlog - base, 17);
        chk("t6_cnt1", pkt_cnt1, 4'd1);
        chk("t6_cnt0", pkt_cnt0, 4'd0);
`endif

        chk("no_bad_deq", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
